// File: rtl/rps_match_engine_if.sv
// Signal bundle for the rock-paper-scissors match engine.
// Protocol: the engine has no valid/ready pair. A round is requested by a
// rising edge on the level signal start. The engine samples start on each
// clock edge, evaluates the moves captured on that edge, and then waits for
// start to return low before it accepts the next round. new_match is also
// edge-triggered and only acts once a match is finished (state DONE).
interface rps_match_engine_if #(
  parameter int SCORE_W = 4,
  parameter int RCNT_W  = 8
);
  logic [2:0]         p1_move;
  logic [2:0]         p2_move;
  logic               start;
  logic               mode_ext;
  logic               new_match;
  logic [1:0]         state;
  logic [1:0]         round_winner;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [RCNT_W-1:0]  round_cnt;
  logic               match_done;
  logic [1:0]         match_winner;

  modport master (
    output p1_move, p2_move, start, mode_ext, new_match,
    input  state, round_winner, p1_score, p2_score, round_cnt,
           match_done, match_winner
  );

  modport slave (
    input  p1_move, p2_move, start, mode_ext, new_match,
    output state, round_winner, p1_score, p2_score, round_cnt,
           match_done, match_winner
  );
endinterface

// File: rtl/rps_match_engine.sv
// Rock-paper-scissors(-spock-lizard) match engine: plays rounds on start
// edges, keeps per-player scores and a round count, and declares a match
// winner once a player reaches WIN_TARGET round wins.
module rps_match_engine #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 4,
  parameter int RCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rps_match_engine_if.slave mif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EVAL   = 2'b01,
    RESULT = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);

  state_t             state_q, state_d;
  logic               start_q, new_match_q, start_arm_q;
  logic               start_edge, new_match_edge;
  logic [2:0]         p1_mv_q, p2_mv_q;
  logic               mode_q;
  logic [1:0]         round_winner_q, match_winner_q;
  logic [SCORE_W-1:0] p1_score_q, p2_score_q;
  logic [RCNT_W-1:0]  round_cnt_q;
  logic [1:0]         round_res;
  logic               target_hit;

  // Winner of one round: 11 invalid move, 00 tie, 01 P1, 10 P2.
  function automatic logic [1:0] judge(input logic [2:0] a, input logic [2:0] b,
                                       input logic ext);
    logic [2:0] lim;
    logic [3:0] d;
    lim = ext ? 3'd4 : 3'd2;
    if ((a > lim) || (b > lim)) return 2'b11;
    if (a == b) return 2'b00;
    d = {1'b0, a} + 4'd5 - {1'b0, b};
    if (d >= 4'd5) d = d - 4'd5;
    if ((d == 4'd1) || (d == 4'd3)) return 2'b01;
    return 2'b10;
  endfunction

  // start only counts once it has been seen low after reset, so a start
  // held high through reset release cannot launch a round.
  assign start_edge     = mif.start & ~start_q & start_arm_q;
  assign new_match_edge = mif.new_match & ~new_match_q;

  // Round result and match-end condition from the captured moves/scores.
  always_comb begin
    round_res  = judge(p1_mv_q, p2_mv_q, mode_q);
    target_hit = (p1_score_q == WIN_T) || (p2_score_q == WIN_T);
  end

  // Edge-detect registers for start and new_match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      new_match_q <= 1'b0;
      start_arm_q <= 1'b0;
    end else begin
      start_q     <= mif.start;
      new_match_q <= mif.new_match;
      start_arm_q <= start_arm_q | ~mif.start;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = EVAL;
      EVAL:    state_d = RESULT;
      RESULT:  if (!mif.start) state_d = target_hit ? DONE : IDLE;
      DONE:    if (new_match_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Move capture, scoring, round counting and match bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_mv_q        <= '0;
      p2_mv_q        <= '0;
      mode_q         <= 1'b0;
      round_winner_q <= 2'b00;
      match_winner_q <= 2'b00;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      round_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            p1_mv_q <= mif.p1_move;
            p2_mv_q <= mif.p2_move;
            // Game mode is fixed for the whole match once a round has counted.
            if (round_cnt_q == '0) mode_q <= mif.mode_ext;
          end
        end
        EVAL: begin
          round_winner_q <= round_res;
          if ((round_res == 2'b01) && (p1_score_q < WIN_T))
            p1_score_q <= p1_score_q + 1'b1;
          if ((round_res == 2'b10) && (p2_score_q < WIN_T))
            p2_score_q <= p2_score_q + 1'b1;
          if ((round_res != 2'b11) && (round_cnt_q != '1))
            round_cnt_q <= round_cnt_q + 1'b1;
        end
        RESULT: begin
          if (!mif.start && target_hit)
            match_winner_q <= (p1_score_q == WIN_T) ? 2'b01 : 2'b10;
        end
        DONE: begin
          if (new_match_edge) begin
            round_winner_q <= 2'b00;
            match_winner_q <= 2'b00;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            round_cnt_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output drive: state is exposed directly, match_done decodes DONE.
  always_comb begin
    mif.state        = state_q;
    mif.round_winner = round_winner_q;
    mif.p1_score     = p1_score_q;
    mif.p2_score     = p2_score_q;
    mif.round_cnt    = round_cnt_q;
    mif.match_done   = (state_q == DONE);
    mif.match_winner = match_winner_q;
  end

endmodule

// File: tb/tb_rps_match_engine.sv
// Directed bench for rps_match_engine with hand-computed expectations.
module tb_rps_match_engine;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rps_match_engine_if #(.SCORE_W(4), .RCNT_W(8)) mif ();

  rps_match_engine #(.WIN_TARGET(3), .SCORE_W(4), .RCNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one full round, start pulse then release back to low.
  task automatic play(input logic [2:0] a, input logic [2:0] b);
    mif.p1_move = a;
    mif.p2_move = b;
    mif.start   = 1'b1;
    tick();
    tick();
    mif.start   = 1'b0;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(mif.state), 32'd0);
    chk({tag, "_rw"},    32'(mif.round_winner), 32'd0);
    chk({tag, "_p1"},    32'(mif.p1_score), 32'd0);
    chk({tag, "_p2"},    32'(mif.p2_score), 32'd0);
    chk({tag, "_cnt"},   32'(mif.round_cnt), 32'd0);
    chk({tag, "_md"},    32'(mif.match_done), 32'd0);
    chk({tag, "_mw"},    32'(mif.match_winner), 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    mif.p1_move   = 3'd0;
    mif.p2_move   = 3'd0;
    mif.start     = 1'b0;
    mif.mode_ext  = 1'b0;
    mif.new_match = 1'b0;
    #12;
    chk_zero("reset");

    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Classic rock vs scissors; p1 move changes after capture.
    mif.p1_move = 3'd0;
    mif.p2_move = 3'd2;
    mif.start   = 1'b1;
    tick();
    chk("a_eval_state", 32'(mif.state), 32'd1);
    mif.p1_move = 3'd1;
    tick();
    chk("a_result_state", 32'(mif.state), 32'd2);
    chk("a_rw", 32'(mif.round_winner), 32'd1);
    chk("a_p1", 32'(mif.p1_score), 32'd1);
    chk("a_cnt", 32'(mif.round_cnt), 32'd1);
    tick();
    chk("a_hold_result", 32'(mif.state), 32'd2);
    mif.start = 1'b0;
    tick();
    chk("a_idle", 32'(mif.state), 32'd0);

    // new_match outside DONE has no effect.
    mif.new_match = 1'b1;
    tick();
    chk("nm_ign_state", 32'(mif.state), 32'd0);
    chk("nm_ign_p1", 32'(mif.p1_score), 32'd1);
    chk("nm_ign_cnt", 32'(mif.round_cnt), 32'd1);
    mif.new_match = 1'b0;
    tick();

    // Mode locked to classic mid-match: lizard and spock are invalid.
    mif.mode_ext = 1'b1;
    play(3'd4, 3'd0);
    chk("b_liz_rw", 32'(mif.round_winner), 32'd3);
    chk("b_liz_p1", 32'(mif.p1_score), 32'd1);
    chk("b_liz_p2", 32'(mif.p2_score), 32'd0);
    chk("b_liz_cnt", 32'(mif.round_cnt), 32'd1);
    play(3'd3, 3'd0);
    chk("b_spk_rw", 32'(mif.round_winner), 32'd3);
    chk("b_spk_cnt", 32'(mif.round_cnt), 32'd1);
    chk("b_state", 32'(mif.state), 32'd0);

    // Asynchronous reset while in EVAL; start held through release.
    mif.p1_move = 3'd0;
    mif.p2_move = 3'd2;
    mif.start   = 1'b1;
    tick();
    chk("c_eval_state", 32'(mif.state), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("c_rst_eval");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("c_norun_state", 32'(mif.state), 32'd0);
    chk("c_norun_cnt", 32'(mif.round_cnt), 32'd0);
    mif.start = 1'b0;
    tick();

    // Classic match: P2 takes three wins with one tie in between.
    mif.mode_ext = 1'b0;
    play(3'd0, 3'd1);
    chk("d1_rw", 32'(mif.round_winner), 32'd2);
    chk("d1_p2", 32'(mif.p2_score), 32'd1);
    play(3'd1, 3'd1);
    chk("d2_rw", 32'(mif.round_winner), 32'd0);
    chk("d2_cnt", 32'(mif.round_cnt), 32'd2);
    play(3'd1, 3'd2);
    chk("d3_rw", 32'(mif.round_winner), 32'd2);
    chk("d3_state", 32'(mif.state), 32'd0);
    play(3'd2, 3'd0);
    chk("d4_state", 32'(mif.state), 32'd3);
    chk("d4_md", 32'(mif.match_done), 32'd1);
    chk("d4_mw", 32'(mif.match_winner), 32'd2);
    chk("d4_cnt", 32'(mif.round_cnt), 32'd4);
    chk("d4_p2", 32'(mif.p2_score), 32'd3);
    chk("d4_p1", 32'(mif.p1_score), 32'd0);
    play(3'd0, 3'd2);
    chk("d5_ign_state", 32'(mif.state), 32'd3);
    chk("d5_ign_cnt", 32'(mif.round_cnt), 32'd4);
    chk("d5_ign_rw", 32'(mif.round_winner), 32'd2);
    mif.new_match = 1'b1;
    tick();
    chk_zero("d_newmatch");
    mif.new_match = 1'b0;
    tick();

    // Extended match won by P1.
    mif.mode_ext = 1'b1;
    play(3'd4, 3'd3);
    chk("e1_rw", 32'(mif.round_winner), 32'd1);
    chk("e1_p1", 32'(mif.p1_score), 32'd1);
    play(3'd0, 3'd3);
    chk("e2_rw", 32'(mif.round_winner), 32'd2);
    chk("e2_p2", 32'(mif.p2_score), 32'd1);
    chk("e2_cnt", 32'(mif.round_cnt), 32'd2);
    play(3'd1, 3'd0);
    chk("e3_p1", 32'(mif.p1_score), 32'd2);
    play(3'd3, 3'd2);
    chk("e4_state", 32'(mif.state), 32'd3);
    chk("e4_mw", 32'(mif.match_winner), 32'd1);
    chk("e4_cnt", 32'(mif.round_cnt), 32'd4);

    // Asynchronous reset while in DONE; start held through release.
    mif.start = 1'b1;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("f_rst_done");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("f_norun_state", 32'(mif.state), 32'd0);
    chk("f_norun_cnt", 32'(mif.round_cnt), 32'd0);
    mif.start = 1'b0;
    tick();
    play(3'd0, 3'd2);
    chk("f_after_rw", 32'(mif.round_winner), 32'd1);
    chk("f_after_cnt", 32'(mif.round_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
